// File: rtl/nx_ram_1rw_fifo_ctl.sv
// FIFO controller: words are stored in an external single-port RAM and
// drained through a 2-entry registered output buffer (capacity DEPTH+2).
module nx_ram_1rw_fifo_ctl #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [WIDTH-1:0]           wr_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       ram_cs,
   output logic                       ram_we,
   output logic [$clog2(DEPTH)-1:0]   ram_add,
   output logic [WIDTH-1:0]           ram_din,
   output logic [WIDTH-1:0]           ram_bwe,
   input  logic [WIDTH-1:0]           ram_dout,
   output logic [$clog2(DEPTH+3)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 3);
   localparam int unsigned NW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [NW-1:0] RAM_FULL = NW'(DEPTH);

   // registered state
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [NW-1:0]    ram_cnt_q, ram_cnt_d;
   logic             inflight_q, inflight_d;
   logic [1:0]       obuf_cnt_q, obuf_cnt_d;
   logic             rr_q, rr_d;
   logic [WIDTH-1:0] obuf0_q, obuf0_d;
   logic [WIDTH-1:0] obuf1_q, obuf1_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;

   // combinational control
   logic             pop_fire;
   logic [2:0]       occ;
   logic             rd_req;
   logic             wr_req;
   logic             conflict;
   logic             rd_grant;
   logic             wr_ok;
   logic             wr_fire;
   logic [1:0]       obuf_base;

   // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of 2).
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + AW'(1);
   endfunction

   // Request, arbitration and grant decode. Reset only gates the outputs:
   // the flops are held by the async reset, so next-state uses ungated terms.
   always_comb begin
      pop_fire = rd_valid && rd_ready;
      occ      = 3'(obuf_cnt_q) + 3'(inflight_q) - 3'(pop_fire);
      rd_req   = (ram_cnt_q != '0) && (occ < 3'd2);
      wr_req   = (ram_cnt_q < RAM_FULL);
      conflict = rd_req && wr_req && wr_valid;
      rd_grant = rd_req && (!(wr_req && wr_valid) || rr_q);
      wr_ok    = wr_req && !(rd_req && rr_q);
      wr_fire  = wr_valid && wr_ok;
   end

   // RAM port and handshake outputs.
   always_comb begin
      wr_ready = wr_ok && !rst;
      ram_cs   = (rd_grant || wr_fire) && !rst;
      ram_we   = wr_fire && !rst;
      ram_add  = wr_fire ? wr_ptr_q : rd_ptr_q;
      ram_din  = wr_data;
      ram_bwe  = '1;
      rd_valid = (obuf_cnt_q != 2'd0);
      rd_data  = obuf0_q;
      count    = count_q;
      full     = full_q;
      empty    = empty_q;
   end

   // Next-state: pointers, occupancy, arbitration priority and output buffer.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rr_d       = rr_q;
      obuf0_d    = obuf0_q;
      obuf1_d    = obuf1_q;
      inflight_d = rd_grant;

      if (wr_fire) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_grant) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      ram_cnt_d = ram_cnt_q + NW'(wr_fire) - NW'(rd_grant);

      if (conflict) begin
         rr_d = ~rr_q;
      end

      // Pop shifts the buffer first; returning RAM data lands behind survivors.
      obuf_base = obuf_cnt_q - 2'(pop_fire);
      if (pop_fire) begin
         obuf0_d = obuf1_q;
      end
      if (inflight_q) begin
         if (obuf_base == 2'd0) begin
            obuf0_d = ram_dout;
         end else begin
            obuf1_d = ram_dout;
         end
      end
      obuf_cnt_d = obuf_base + 2'(inflight_q);

      count_d = CW'(ram_cnt_d) + CW'(inflight_d) + CW'(obuf_cnt_d);
      full_d  = (ram_cnt_d == RAM_FULL);
      empty_d = (count_d == '0);
   end

   // State register with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         inflight_q <= 1'b0;
         obuf_cnt_q <= 2'd0;
         rr_q       <= 1'b0;
         obuf0_q    <= '0;
         obuf1_q    <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         inflight_q <= inflight_d;
         obuf_cnt_q <= obuf_cnt_d;
         rr_q       <= rr_d;
         obuf0_q    <= obuf0_d;
         obuf1_q    <= obuf1_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
      end
   end

endmodule

// File: tb/tb_nx_ram_1rw_fifo_ctl.sv
// Directed bench for nx_ram_1rw_fifo_ctl with a behavioural single-port RAM.
module tb_nx_ram_1rw_fifo_ctl;

   localparam int unsigned W  = 16;
   localparam int unsigned D  = 4;
   localparam int unsigned AW = 2;
   localparam int unsigned CW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid;
   logic          wr_ready;
   logic [W-1:0]  wr_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [W-1:0]  rd_data;
   logic          ram_cs;
   logic          ram_we;
   logic [AW-1:0] ram_add;
   logic [W-1:0]  ram_din;
   logic [W-1:0]  ram_bwe;
   logic [W-1:0]  ram_dout;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   int n_tests = 0;
   int n_fail  = 0;
   int n_ram_wr = 0;
   int n_ram_rd = 0;
   int n_pop    = 0;
   logic [W-1:0]  sb_q[$];
   logic [AW-1:0] exp_wa = '0;
   logic [AW-1:0] exp_ra = '0;
   logic [AW-1:0] last_wa = '0;
   bit            saw_wrap = 1'b0;
   logic [W-1:0]  mem [D];

   nx_ram_1rw_fifo_ctl #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_add(ram_add),
      .ram_din(ram_din), .ram_bwe(ram_bwe), .ram_dout(ram_dout),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Single-port RAM, read data valid the cycle after the select.
   always @(posedge clk) begin
      if (ram_cs && ram_we) mem[ram_add] <= ram_din;
      if (ram_cs && !ram_we) ram_dout <= mem[ram_add];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Offer one word until accepted (bounded); wr_valid is left high.
   task automatic push_word(input logic [W-1:0] d, input string tag);
      bit ok;
      wr_valid = 1'b1;
      wr_data  = d;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         mid();
         ok = wr_ready;
         cyc();
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   // Wait (bounded) until empty is seen at mid-cycle.
   task automatic wait_empty(input string tag);
      bit e;
      e = 1'b0;
      for (int c = 0; c < 60 && !e; c++) begin
         mid();
         e = empty;
         if (!e) cyc();
      end
      check(tag, 32'(e), 32'd1);
   endtask

   // Scoreboard and RAM address sequencing, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         exp_wa = '0;
         exp_ra = '0;
      end else begin
         if (ram_cs && ram_we) begin
            check("ram_wr_add", 32'(ram_add), 32'(exp_wa));
            if (last_wa == AW'(D - 1) && ram_add == '0) saw_wrap = 1'b1;
            last_wa = ram_add;
            exp_wa  = exp_wa + AW'(1);
            n_ram_wr++;
         end else if (ram_cs) begin
            check("ram_rd_add", 32'(ram_add), 32'(exp_ra));
            exp_ra = exp_ra + AW'(1);
            n_ram_rd++;
         end
         if (wr_valid && wr_ready) begin
            check("wr_din", 32'({ram_cs, ram_we, ram_din}), 32'({2'b11, wr_data}));
            sb_q.push_back(wr_data);
         end
         if (rd_valid && rd_ready) begin
            n_pop++;
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
               check("sb_order", 32'(rd_data), 32'(sb_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int rd0, wr0, p0, sent;
      bit got;
      logic [W-1:0] nxt;

      // Reset values
      rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
      repeat (2) cyc();
      mid();
      check("rst_wr_ready", 32'(wr_ready), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_ram_cs", 32'({ram_cs, ram_we}), 32'd0);
      check("rst_flags", 32'({count, full, empty}), 32'b000_0_1);
      check("ram_bwe", 32'(ram_bwe), 32'hFFFF);
      cyc();
      rst = 1'b0;
      mid();
      check("wr_ready_after_rst", 32'(wr_ready), 32'd1);

      // Single word: write cycle 0, read cycle 1, present cycle 3
      cyc();
      wr_valid = 1'b1; wr_data = 16'h00A5; rd_ready = 1'b1;
      mid();
      check("sw_c0_ram", 32'({ram_cs, ram_we, ram_add, ram_din}), 32'({2'b11, 2'd0, 16'h00A5}));
      cyc();
      wr_valid = 1'b0;
      mid();
      check("sw_c1_ram", 32'({ram_cs, ram_we, ram_add}), 32'({2'b10, 2'd0}));
      check("sw_c1_cnt", 32'({count, rd_valid}), 32'({3'd1, 1'b0}));
      cyc(); mid();
      check("sw_c2", 32'({ram_cs, rd_valid, count}), 32'({1'b0, 1'b0, 3'd1}));
      cyc(); mid();
      check("sw_c3", 32'({rd_valid, rd_data}), 32'({1'b1, 16'h00A5}));
      cyc(); mid();
      check("sw_c4", 32'({empty, rd_valid, count}), 32'({1'b1, 1'b0, 3'd0}));
      cyc();

      // Fill to DEPTH+2 with no pops, then 20 cycles of backpressure
      rd_ready = 1'b0;
      rd0 = n_ram_rd; wr0 = n_ram_wr;
      for (int i = 0; i < 6; i++) push_word(16'(16'h0100 + i), "fill_accept");
      wr_data = 16'hDEAD;
      for (int c = 0; c < 20; c++) begin
         mid();
         check("bp_ready", 32'({wr_ready, ram_cs}), 32'd0);
         check("bp_flags", 32'({count, full, empty}), 32'({3'd6, 1'b1, 1'b0}));
         check("bp_rd_data", 32'({rd_valid, rd_data}), 32'({1'b1, 16'h0100}));
         cyc();
      end
      check("bp_ram_reads", 32'(n_ram_rd - rd0), 32'd2);
      check("fill_ram_writes", 32'(n_ram_wr - wr0), 32'd6);
      wr_valid = 1'b0; rd_ready = 1'b1;
      p0 = n_pop;
      wait_empty("fill_drain");
      check("fill_pops", 32'(n_pop - p0), 32'd6);
      cyc();

      // Wrap: 10 incrementing words with random rd_ready
      saw_wrap = 1'b0; sent = 0; p0 = n_pop;
      for (int c = 0; c < 300 && (n_pop - p0) < 10; c++) begin
         wr_valid = (sent < 10);
         wr_data  = 16'(sent);
         rd_ready = 1'($urandom_range(0, 1));
         mid();
         if (wr_valid && wr_ready) sent++;
         cyc();
      end
      wr_valid = 1'b0;
      check("wrap_pops", 32'(n_pop - p0), 32'd10);
      check("wrap_seen", 32'(saw_wrap), 32'd1);
      check("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

      // Reset in the cycle after a read grant
      rd_ready = 1'b0;
      push_word(16'h0BEE, "rr_push");
      wr_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
         mid();
         got = ram_cs && !ram_we;
         cyc();
      end
      check("rr_grant_seen", 32'(got), 32'd1);
      rst = 1'b1;
      #1;
      check("rr_outs", 32'({wr_ready, rd_valid, ram_cs, ram_we}), 32'd0);
      check("rr_rd_data", 32'(rd_data), 32'd0);
      check("rr_flags", 32'({count, full, empty}), 32'b000_0_1);
      cyc();
      rst = 1'b0; rd_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         mid();
         check("rr_post_empty", 32'({empty, rd_valid}), 32'b10);
         cyc();
      end
      push_word(16'h1234, "rr_push2");
      wr_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         mid();
         got = rd_valid;
         if (!got) cyc();
      end
      check("rr_own_data", 32'({got, rd_data}), 32'({1'b1, 16'h1234}));
      cyc(); mid();
      check("rr_final_empty", 32'(empty), 32'd1);
      cyc();

      // Contention: clean start, preload 3 words, then push and pop continuously
      rst = 1'b1; rd_ready = 1'b0;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) push_word(16'(16'h0200 + i), "pre_accept");
      rd_ready = 1'b1;
      nxt = 16'h0203;
      wr0 = n_ram_wr; p0 = n_pop;
      for (int c = 0; c < 20; c++) begin
         wr_data = nxt;
         mid();
         check("cont_grant", 32'({ram_cs, ram_we}), 32'({1'b1, 1'(c & 1)}));
         check("cont_count", 32'(count >= 3'd2 && count <= 3'd3), 32'd1);
         if (wr_ready) nxt = nxt + 16'd1;
         cyc();
      end
      check("cont_writes", 32'(n_ram_wr - wr0), 32'd10);
      check("cont_pops", 32'(n_pop - p0), 32'd10);
      wr_valid = 1'b0;
      wait_empty("cont_drain");
      check("cont_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
